// File: rtl/token_buffer.sv
// Activation token store: valid/ready write port, pipelined read responder with per-entry valid bitmap.
// Optional per-lane even parity on stored entries when TBUF_PARITY_EN is defined.
module token_buffer #(
    parameter int AW     = 8,
    parameter int DW     = 1024,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          clr,
    input  logic          tbuf_rd_en,
    input  logic [AW-1:0] tbuf_rd_addr,
    output logic [DW-1:0] tbuf_rd_data,
    output logic          tbuf_rd_valid,
    output logic [AW:0]   valid_cnt,
    output logic [15:0]   rd_miss_cnt,
    output logic          rd_par_err
);

    localparam int DEPTH = 1 << AW;
    localparam int LANES = DW / 64;

    logic             ready_reg;
    logic [DEPTH-1:0] bitmap_reg;
    logic [AW:0]      valid_cnt_reg;
    logic [15:0]      miss_cnt_reg;

    logic wr_acc;
    logic fwd_hit;
    logic entry_hit;
    logic rd_hit;
    logic rd_miss;

    assign wr_ready  = ready_reg & ~clr;
    assign wr_acc    = wr_valid & wr_ready;
    assign fwd_hit   = wr_acc & (wr_addr == tbuf_rd_addr);
    assign entry_hit = bitmap_reg[tbuf_rd_addr] | fwd_hit;
    assign rd_hit    = tbuf_rd_en & entry_hit;
    assign rd_miss   = tbuf_rd_en & ~entry_hit;

    // Bitmap, occupancy and miss bookkeeping; reads in a clr cycle use the pre-clear bitmap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg     <= 1'b0;
            bitmap_reg    <= '0;
            valid_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
        end else begin
            ready_reg <= 1'b1;
            if (clr) begin
                bitmap_reg    <= '0;
                valid_cnt_reg <= '0;
            end else if (wr_acc) begin
                bitmap_reg[wr_addr] <= 1'b1;
                if (!bitmap_reg[wr_addr]) begin
                    valid_cnt_reg <= valid_cnt_reg + (AW+1)'(1);
                end
            end
            if (rd_miss && (miss_cnt_reg != 16'hFFFF)) begin
                miss_cnt_reg <= miss_cnt_reg + 16'd1;
            end
        end
    end

    assign valid_cnt   = valid_cnt_reg;
    assign rd_miss_cnt = miss_cnt_reg;

    // Storage array with registered, read-first port; same-address writes are forwarded separately.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] raw_reg;
    logic [DW-1:0] fwd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_hit) begin
            raw_reg <= mem[tbuf_rd_addr];
        end
        if (rd_hit && fwd_hit) begin
            fwd_data_reg <= wr_data;
        end
    end

    logic          s1_vld_reg;
    logic          s1_fwd_reg;
    logic [DW-1:0] s1_data;
    logic          s1_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_reg <= 1'b0;
            s1_fwd_reg <= 1'b0;
        end else begin
            s1_vld_reg <= rd_hit;
            if (rd_hit) begin
                s1_fwd_reg <= fwd_hit;
            end
        end
    end

    assign s1_data = s1_fwd_reg ? fwd_data_reg : raw_reg;

`ifdef TBUF_PARITY_EN
    logic [LANES-1:0] wr_par;
    logic [LANES-1:0] par_mem [DEPTH];
    logic [LANES-1:0] par_reg;
    logic [LANES-1:0] lane_err;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign wr_par[gi]   = ^wr_data[gi*64 +: 64];
            assign lane_err[gi] = (^raw_reg[gi*64 +: 64]) ^ par_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            par_mem[wr_addr] <= wr_par;
        end
        if (rd_hit) begin
            par_reg <= par_mem[tbuf_rd_addr];
        end
    end

    // Forwarded data never went through storage, so it cannot carry a parity fault.
    assign s1_err = ~s1_fwd_reg & (|lane_err);
`else
    assign s1_err = 1'b0;
`endif

    generate
        if (RD_LAT == 1) begin : g_lat1
            // Storage output is unreset, so hide it until the first hit after reset.
            logic have_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    have_reg <= 1'b0;
                end else if (rd_hit) begin
                    have_reg <= 1'b1;
                end
            end
            assign tbuf_rd_valid = s1_vld_reg;
            assign tbuf_rd_data  = have_reg ? s1_data : '0;
            assign rd_par_err    = s1_vld_reg & s1_err;
        end else begin : g_latn
            logic [RD_LAT-2:0] dv_reg;
            logic [RD_LAT-2:0] de_reg;
            logic [DW-1:0]     dd_reg [RD_LAT-1];

            // Data stages load only on valid, so the last stage holds the previous response.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dv_reg <= '0;
                    de_reg <= '0;
                    for (int i = 0; i < RD_LAT-1; i++) begin
                        dd_reg[i] <= '0;
                    end
                end else begin
                    dv_reg[0] <= s1_vld_reg;
                    if (s1_vld_reg) begin
                        dd_reg[0] <= s1_data;
                        de_reg[0] <= s1_err;
                    end
                    for (int i = 1; i < RD_LAT-1; i++) begin
                        dv_reg[i] <= dv_reg[i-1];
                        if (dv_reg[i-1]) begin
                            dd_reg[i] <= dd_reg[i-1];
                            de_reg[i] <= de_reg[i-1];
                        end
                    end
                end
            end
            assign tbuf_rd_valid = dv_reg[RD_LAT-2];
            assign tbuf_rd_data  = dd_reg[RD_LAT-2];
            assign rd_par_err    = dv_reg[RD_LAT-2] & de_reg[RD_LAT-2];
        end
    endgenerate

endmodule

// File: tb/tb_token_buffer.sv
// Bench for token_buffer: two instances (RD_LAT=1 and RD_LAT=3) on shared stimulus, scoreboard per instance.
// Parity corruption scenario runs only when TBUF_PARITY_EN is defined.
module tb_token_buffer;

    localparam int AW = 8;
    localparam int DW = 256;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
        logic          perr;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          clr;
    logic          tbuf_rd_en;
    logic [AW-1:0] tbuf_rd_addr;

    logic          wr_ready1, wr_ready3;
    logic [DW-1:0] rd_data1, rd_data3;
    logic          rd_valid1, rd_valid3;
    logic [AW:0]   valid_cnt1, valid_cnt3;
    logic [15:0]   miss1, miss3;
    logic          perr1, perr3;

    token_buffer #(.AW(AW), .DW(DW), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr(clr), .tbuf_rd_en(tbuf_rd_en), .tbuf_rd_addr(tbuf_rd_addr),
        .tbuf_rd_data(rd_data1), .tbuf_rd_valid(rd_valid1),
        .valid_cnt(valid_cnt1), .rd_miss_cnt(miss1), .rd_par_err(perr1)
    );

    token_buffer #(.AW(AW), .DW(DW), .RD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready3), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr(clr), .tbuf_rd_en(tbuf_rd_en), .tbuf_rd_addr(tbuf_rd_addr),
        .tbuf_rd_data(rd_data3), .tbuf_rd_valid(rd_valid3),
        .valid_cnt(valid_cnt3), .rd_miss_cnt(miss3), .rd_par_err(perr3)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t q1[$];
    exp_t q3[$];
    exp_t e1;
    exp_t e3;

    logic             model_ready;
    logic [255:0]     model_valid;
    logic [255:0]     model_bad;
    logic [DW-1:0]    model_mem [256];
    int               model_cnt;
    logic [15:0]      model_miss;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    always @(negedge clk) begin
        if (rst_n && rd_valid1) begin
            if (q1.size() == 0) begin
                check("lat1_unexpected_valid", rd_valid1, 1'b0);
            end else begin
                e1 = q1.pop_front();
                check("lat1_data", rd_data1, e1.data);
                check("lat1_latency", cyc - e1.cyc, 1);
                check("lat1_perr", perr1, e1.perr);
                $display("lat1 resp data=%0h perr=%0b", rd_data1, perr1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rd_valid3) begin
            if (q3.size() == 0) begin
                check("lat3_unexpected_valid", rd_valid3, 1'b0);
            end else begin
                e3 = q3.pop_front();
                check("lat3_data", rd_data3, e3.data);
                check("lat3_latency", cyc - e3.cyc, 3);
                check("lat3_perr", perr3, e3.perr);
                $display("lat3 resp data=%0h perr=%0b", rd_data3, perr3);
            end
        end
    end

    // One clock of stimulus; the model decides hit/miss at issue and queues expected responses.
    task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic c, input logic re, input logic [AW-1:0] ra);
        logic acc, fwd, hit;
        exp_t e;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        clr = c; tbuf_rd_en = re; tbuf_rd_addr = ra;
        #1;
        if (wv || c) begin
            check("wr_ready_lat1", wr_ready1, model_ready & ~c);
            check("wr_ready_lat3", wr_ready3, model_ready & ~c);
        end
        acc = wv & model_ready & ~c;
        fwd = acc && (wa == ra);
        hit = re && (model_valid[ra] || fwd);
        if (hit) begin
            e.data = fwd ? wd : model_mem[ra];
            e.cyc  = cyc;
            e.perr = fwd ? 1'b0 : model_bad[ra];
            q1.push_back(e);
            q3.push_back(e);
        end else if (re && model_miss != 16'hFFFF) begin
            model_miss = model_miss + 16'd1;
        end
        if (c) begin
            model_valid = '0;
            model_cnt   = 0;
        end else if (acc) begin
            if (!model_valid[wa]) model_cnt++;
            model_valid[wa] = 1'b1;
            model_mem[wa]   = wd;
            model_bad[wa]   = 1'b0;
        end
        if (wv || c || re)
            $display("cyc %0d wr=%0b@%0h clr=%0b rd=%0b@%0h hit=%0b", cyc, wv, wa, c, re, ra, hit);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q3.size() != 0) && n < 20) begin
            idle();
            n++;
        end
        idle();
        check("drain_pending", q1.size() + q3.size(), 0);
    endtask

    task automatic check_counts();
        check("valid_cnt_lat1", valid_cnt1, model_cnt);
        check("valid_cnt_lat3", valid_cnt3, model_cnt);
        check("miss_cnt_lat1", miss1, model_miss);
        check("miss_cnt_lat3", miss3, model_miss);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_valid = 1'b0; clr = 1'b0; tbuf_rd_en = 1'b0;
        q1.delete(); q3.delete();
        model_ready = 1'b0; model_valid = '0; model_cnt = 0; model_miss = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_lat1", rd_valid1, 1'b0);
        check("rst_valid_lat3", rd_valid3, 1'b0);
        check("rst_data_lat1", rd_data1, '0);
        check("rst_data_lat3", rd_data3, '0);
        check("rst_perr_lat1", perr1, 1'b0);
        check("rst_perr_lat3", perr3, 1'b0);
        check("rst_ready_lat1", wr_ready1, 1'b0);
        check("rst_ready_lat3", wr_ready3, 1'b0);
        check_counts();
        rst_n = 1'b1;
        #1;
        check("ready_after_release_lat1", wr_ready1, 1'b0);
        check("ready_after_release_lat3", wr_ready3, 1'b0);
        @(posedge clk); #1;
        model_ready = 1'b1;
        check("ready_settled_lat1", wr_ready1, 1'b1);
        check("ready_settled_lat3", wr_ready3, 1'b1);
        $display("reset done at cyc %0d", cyc);
    endtask

    logic [DW-1:0] pat_a, pat_b, pat_c, pat_d;

    initial begin
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0;
        tbuf_rd_en = 1'b0; tbuf_rd_addr = '0; rst_n = 1'b0;
        model_bad = '0;
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        do_reset();

        // Basic write then read
        pat_a = rand_data();
        step(1'b1, 8'h10, pat_a, 1'b0, 1'b0, '0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h10);
        drain();
        check_counts();
        check("hold_data_lat1", rd_data1, pat_a);
        check("hold_valid_lat1", rd_valid1, 1'b0);

        // Re-issued reads to an unwritten entry miss until it is written
        for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 8'h20);
        check_counts();
        pat_b = rand_data();
        step(1'b1, 8'h20, pat_b, 1'b0, 1'b0, '0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h20);
        drain();

        // Same-cycle write and read forwards the new data
        pat_c = rand_data();
        step(1'b1, 8'h30, pat_c, 1'b0, 1'b1, 8'h30);
        drain();
        check_counts();

        // Back-to-back reads, then read/write to different addresses together
        for (int i = 1; i <= 4; i++) step(1'b1, AW'(i), rand_data(), 1'b0, 1'b0, '0);
        for (int i = 1; i <= 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1, AW'(i));
        step(1'b1, 8'h05, rand_data(), 1'b0, 1'b1, 8'h02);
        step(1'b1, 8'h06, rand_data(), 1'b0, 1'b1, 8'h05);
        step(1'b1, 8'h01, rand_data(), 1'b0, 1'b1, 8'h06);
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h01);
        drain();
        check_counts();

        // Fill, rewrite, clear
        for (int a = 0; a < 256; a++) step(1'b1, AW'(a), rand_data(), 1'b0, 1'b0, '0);
        check_counts();
        step(1'b1, 8'h00, rand_data(), 1'b0, 1'b0, '0);
        check_counts();
        step(1'b1, 8'h50, rand_data(), 1'b1, 1'b1, 8'h00);
        check_counts();
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h00);
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h50);
        drain();
        check_counts();

`ifdef TBUF_PARITY_EN
        begin
            logic [DW-1:0] tmp;
            pat_d = rand_data();
            step(1'b1, 8'h40, pat_d, 1'b0, 1'b0, '0);
            step(1'b1, 8'h41, rand_data(), 1'b0, 1'b0, '0);
            tmp = u_lat1.mem[8'h40]; tmp[3*64+5] = ~tmp[3*64+5]; u_lat1.mem[8'h40] = tmp;
            tmp = u_lat3.mem[8'h40]; tmp[3*64+5] = ~tmp[3*64+5]; u_lat3.mem[8'h40] = tmp;
            model_mem[8'h40][3*64+5] = ~model_mem[8'h40][3*64+5];
            model_bad[8'h40] = 1'b1;
            step(1'b0, '0, '0, 1'b0, 1'b1, 8'h40);
            step(1'b0, '0, '0, 1'b0, 1'b1, 8'h41);
            step(1'b1, 8'h40, pat_d, 1'b0, 1'b1, 8'h40);
            drain();
        end
`else
        pat_d = rand_data();
        step(1'b1, 8'h40, pat_d, 1'b0, 1'b0, '0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h40);
        drain();
`endif

        // Reset with a response still in flight in the deeper pipeline
        step(1'b1, 8'h07, rand_data(), 1'b0, 1'b0, '0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h07);
        idle();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 8'h07);
        idle(); idle(); idle();
        check("post_rst_data_lat1", rd_data1, '0);
        check("post_rst_data_lat3", rd_data3, '0);
        check_counts();
        step(1'b1, 8'h07, rand_data(), 1'b0, 1'b0, '0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 8'h07);
        drain();
        check_counts();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/token_buffer.md
Name: token_buffer

Overview:
- On-chip activation token store; the responder side of the read interface used by the activation dispatcher: tbuf_rd_en/tbuf_rd_addr in, tbuf_rd_data/tbuf_rd_valid out.
- Upstream loader fills entries through a valid/ready write port.
- A per-entry valid bitmap suppresses responses for entries not yet written, so a requester that keeps re-issuing a read naturally waits for the data.

Parameters:
- AW, 8, address width; depth = 2**AW entries (256).
- DW, 1024, entry data width; must be a multiple of 64.
- RD_LAT, 1, read response latency in cycles; legal range 1..4.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write can be accepted this cycle.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- clr  in  1  single-cycle pulse; invalidates all entries.
- tbuf_rd_en  in  1  read request; each asserted cycle is an independent request.
- tbuf_rd_addr  in  AW  read address.
- tbuf_rd_data  out  DW  read data.
- tbuf_rd_valid  out  1  read data valid, one-cycle pulse per hit.
- valid_cnt  out  AW+1  number of currently valid entries.
- rd_miss_cnt  out  16  saturating count of reads to invalid entries.
- rd_par_err  out  1  parity error flag aligned with tbuf_rd_valid (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - Bitmap all 0; valid_cnt=0; rd_miss_cnt=0.
  - tbuf_rd_valid=0; tbuf_rd_data=0; rd_par_err=0; wr_ready=0.
  - Read pipeline flushed. Storage contents are not reset.
- wr_ready:
  - 0 during reset and in the first cycle after rst_n deasserts; 1 otherwise.
  - Forced 0 in the cycle clr is asserted.
- Write accept = wr_valid & wr_ready:
  - Stores wr_data at wr_addr and sets the entry's valid bit.
  - valid_cnt increments only if the entry was previously invalid; a rewrite of a valid entry leaves the count unchanged.
- clr:
  - All valid bits and valid_cnt clear on the next edge.
  - No write is accepted in that cycle (wr_ready=0).
  - Reads issued in the clr cycle still see the pre-clear bitmap.
  - Responses already in the pipeline complete normally.
- Read issue (tbuf_rd_en=1), hit/miss determined at the issue cycle:
  - Hit if the entry's valid bit is set, or if a write to the same address is accepted in the same cycle (write-first forwarding returns the new wr_data).
  - Hit: tbuf_rd_data is driven and tbuf_rd_valid pulses exactly RD_LAT cycles after issue.
  - Miss: no response; rd_miss_cnt += 1, saturating at 16'hFFFF.
- Pipeline:
  - Fully pipelined; back-to-back reads every cycle, one response per hit, returned in issue order.
  - tbuf_rd_data holds its last value when tbuf_rd_valid=0.
  - No backpressure on the read side.
- Simultaneous read and write to different addresses: both proceed; the read sees old bitmap/data.
- Addresses wrap naturally at 2**AW; no out-of-range case exists.
- Reset mid-operation: in-flight responses are discarded; no tbuf_rd_valid after reset release until a new hit.
- valid_cnt range is 0..2**AW; full when valid_cnt == 2**AW. Writes are still accepted when full (rewrite only).

Optional Feature:
- Macro: TBUF_PARITY_EN.
- Defined:
  - Each entry also stores DW/64 even-parity bits, one per 64-bit lane, computed on write.
  - On a hit, stored parity is recomputed against the read data.
  - rd_par_err=1 in the tbuf_rd_valid cycle if any lane mismatches.
  - Forwarded reads never flag an error.
- Not defined: no parity storage; rd_par_err is tied to 0; port list is unchanged.

Test Plan:
- Reset, write addr 8'h10 data pattern A, read 8'h10 with RD_LAT=1 -> tbuf_rd_valid pulses 1 cycle after issue with A; valid_cnt=1.
- Read 8'h20 before it is written, re-issued every cycle for 5 cycles, then write 8'h20=B -> no valid for 5 cycles, rd_miss_cnt=5; next read returns B.
- Same-cycle write 8'h30=C and read 8'h30 -> hit, returns C after RD_LAT; no miss counted.
- RD_LAT=3, reads to 8'h01..8'h04 on 4 consecutive cycles (all valid) -> 4 consecutive valid pulses starting 3 cycles after the first issue, in order.
- Fill all 256 entries, rewrite 8'h00, then pulse clr -> valid_cnt 256 then 256, then 0; wr_ready=0 in the clr cycle; subsequent read 8'h00 misses.
- TBUF_PARITY_EN defined, force a bit flip in stored lane 3 of 8'h40, read it -> tbuf_rd_valid=1 with rd_par_err=1; clean entry read -> rd_par_err=0.
